// File: rtl/xc_shift_rot_iter.sv
// Iterative shift/rotate unit: SLL, SRL, SRA, ROL, ROR over XLEN bits, moving at most
// STEP bit positions per cycle, with a request/response handshake and flush.
module xc_shift_rot_iter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned STEP = 8,
    parameter int unsigned SW   = $clog2(XLEN)
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [SW-1:0]   req_shamt,
    output logic            rsp_valid,
    input  logic            rsp_ack,
    output logic [XLEN-1:0] rsp_result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // One extra bit so STEP == XLEN and XLEN itself are representable.
    localparam logic [SW:0] XLEN_W = (SW+1)'(XLEN);
    localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

    logic [1:0]      state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] data_q;
    logic [SW-1:0]   rem;

    logic [SW-1:0]   step_k;
    logic [SW:0]     step_inv;
    logic [XLEN-1:0] shifted;
    logic            last_step;

    // rem < XLEN always, so the STEP branch is only taken when STEP < XLEN.
    always_comb begin
        step_k    = ({1'b0, rem} < STEP_W) ? rem : STEP_W[SW-1:0];
        step_inv  = XLEN_W - {1'b0, step_k};
        last_step = (rem == step_k);
    end

    always_comb begin
        case (op_q)
            OP_SLL:  shifted = data_q << step_k;
            OP_SRL:  shifted = data_q >> step_k;
            OP_SRA:  shifted = $unsigned($signed(data_q) >>> step_k);
            OP_ROL:  shifted = (data_q << step_k) | (data_q >> step_inv);
            OP_ROR:  shifted = (data_q >> step_k) | (data_q << step_inv);
            default: shifted = '0;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state  <= ST_IDLE;
            op_q   <= '0;
            data_q <= '0;
            rem    <= '0;
        end else if (flush) begin
            state <= ST_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q <= req_op;
                        if (req_op > OP_ROR) begin
                            data_q <= '0;
                            rem    <= '0;
                            state  <= ST_DONE;
                        end else begin
                            data_q <= req_rs1;
                            rem    <= req_shamt;
                            state  <= (req_shamt == '0) ? ST_DONE : ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    data_q <= shifted;
                    rem    <= rem - step_k;
                    if (last_step) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rsp_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign rsp_valid  = (state == ST_DONE);
    assign rsp_result = data_q;

endmodule

// File: tb/tb_xc_shift_rot_iter.sv
// Bench for xc_shift_rot_iter: four instances (STEP 1, 3, 8, 32) share one request stream;
// expected result/latency per instance are queued at issue and checked on response.
module tb_xc_shift_rot_iter;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_rs1;
    logic [4:0]  req_shamt;
    logic [3:0]  rdy;
    logic [3:0]  vld;
    logic [3:0]  ack;
    logic [31:0] res [4];

    typedef struct {
        logic [31:0] res;
        int unsigned lat;
    } exp_t;

    exp_t sb [$];
    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    always #5 g_clk = ~g_clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned ST = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 8 : 32;
        xc_shift_rot_iter #(.XLEN(32), .STEP(ST)) dut (
            .g_clk      (g_clk),
            .g_resetn   (g_resetn),
            .flush      (flush),
            .req_valid  (req_valid),
            .req_ready  (rdy[g]),
            .req_op     (req_op),
            .req_rs1    (req_rs1),
            .req_shamt  (req_shamt),
            .rsp_valid  (vld[g]),
            .rsp_ack    (ack[g]),
            .rsp_result (res[g])
        );
    end

    function automatic int unsigned step_of(int unsigned i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] x, int unsigned s);
        case (op)
            3'd0: return x << s;
            3'd1: return x >> s;
            3'd2: return $unsigned($signed(x) >>> s);
            3'd3: return (s == 0) ? x : ((x << s) | (x >> (32 - s)));
            3'd4: return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic push_exp(input logic [2:0] op, input int unsigned sh, input logic [31:0] r);
        exp_t e;
        for (int unsigned i = 0; i < 4; i++) begin
            e.res = r;
            e.lat = (op > 3'd4 || sh == 0) ? 1 : (sh + step_of(i) - 1) / step_of(i) + 1;
            sb.push_back(e);
        end
    endtask

    // Drive one request for a single cycle; caller guarantees all instances are idle.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, input int unsigned sh,
                         input logic [31:0] r);
        chk("ready_before_issue", {28'h0, rdy}, 32'hF);
        push_exp(op, sh, r);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = x;
        req_shamt = sh[4:0];
        tick();
        req_valid = 1'b0;
    endtask

    // Called right after the accept edge; latency 1 means valid in the first cycle seen here.
    task automatic collect(input string tag);
        int unsigned lat [4];
        bit          seen [4];
        int unsigned c = 1;
        exp_t        e;
        for (int unsigned i = 0; i < 4; i++) begin
            seen[i] = 1'b0;
            lat[i]  = 0;
        end
        forever begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (!seen[i] && vld[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = c;
                end
            end
            if ((seen[0] && seen[1] && seen[2] && seen[3]) || c >= 200) break;
            tick();
            c++;
        end
        for (int unsigned i = 0; i < 4; i++) begin
            e = sb.pop_front();
            chk($sformatf("%s_valid_seen_s%0d", tag, step_of(i)), {31'h0, seen[i]}, 32'h1);
            chk($sformatf("%s_result_s%0d", tag, step_of(i)), res[i], e.res);
            chk($sformatf("%s_latency_s%0d", tag, step_of(i)), lat[i], e.lat);
        end
    endtask

    task automatic ack_all();
        ack = 4'hF;
        tick();
        ack = 4'h0;
        chk("idle_after_ack_ready", {28'h0, rdy}, 32'hF);
        chk("idle_after_ack_valid", {28'h0, vld}, 32'h0);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] x,
                       input int unsigned sh, input logic [31:0] r);
        issue(op, x, sh, r);
        collect(tag);
        ack_all();
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] x;
        int unsigned sh;

        g_resetn  = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_rs1   = 32'h0;
        req_shamt = 5'd0;
        ack       = 4'h0;
        repeat (3) tick();
        g_resetn = 1'b1;
        tick();

        chk("reset_ready", {28'h0, rdy}, 32'hF);
        chk("reset_valid", {28'h0, vld}, 32'h0);
        for (int unsigned i = 0; i < 4; i++) chk($sformatf("reset_result_%0d", i), res[i], 32'h0);

        // Directed vectors
        run("ror4",   3'd4, 32'h80000001, 4,  32'h18000000);
        run("rol31",  3'd3, 32'h12345678, 31, 32'h091A2B3C);
        run("srl28",  3'd1, 32'hF0000000, 28, 32'h0000000F);
        run("sra17",  3'd2, 32'h80000000, 17, 32'hFFFFC000);
        run("sll0",   3'd0, 32'hDEADBEEF, 0,  32'hDEADBEEF);
        run("ror0",   3'd4, 32'hA5A5_0F0F, 0, 32'hA5A5_0F0F);
        run("rsv5",   3'd5, 32'hFFFFFFFF, 13, 32'h0);
        run("rsv7",   3'd7, 32'h12345678, 0,  32'h0);
        run("sll31",  3'd0, 32'h00000003, 31, 32'h80000000);

        // Back-pressure: hold result in DONE while a new request waits
        issue(3'd4, 32'h80000001, 4, 32'h18000000);
        collect("bp_first");
        push_exp(3'd0, 9, 32'h0000_0200);
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_rs1   = 32'h1;
        req_shamt = 5'd9;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_valid", {28'h0, vld}, 32'hF);
            chk("bp_hold_ready", {28'h0, rdy}, 32'h0);
            for (int unsigned i = 0; i < 4; i++) chk("bp_hold_result", res[i], 32'h18000000);
        end
        ack = 4'hF;
        tick();
        ack = 4'h0;
        chk("bp_after_ack_ready", {28'h0, rdy}, 32'hF);
        chk("bp_after_ack_valid", {28'h0, vld}, 32'h0);
        tick();
        req_valid = 1'b0;
        collect("bp_second");
        ack_all();

        // Flush on the second BUSY cycle of a ROR by 20
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_rs1   = 32'hCAFEBABE;
        req_shamt = 5'd20;
        tick();
        req_valid = 1'b0;
        chk("flush_busy1_valid", {29'h0, vld[2:0]}, 32'h0);
        chk("flush_busy1_ready", {28'h0, rdy}, 32'h0);
        tick();
        chk("flush_busy2_valid", {29'h0, vld[2:0]}, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready", {28'h0, rdy}, 32'hF);
        chk("flush_valid", {28'h0, vld}, 32'h0);
        repeat (4) begin
            tick();
            chk("flush_no_valid", {28'h0, vld}, 32'h0);
        end
        run("post_flush", 3'd3, 32'h0000_00F1, 8, 32'h0000_F100);

        // Same abort via reset
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_rs1   = 32'hCAFEBABE;
        req_shamt = 5'd20;
        tick();
        req_valid = 1'b0;
        tick();
        g_resetn = 1'b0;
        tick();
        g_resetn = 1'b1;
        chk("rst_abort_ready", {28'h0, rdy}, 32'hF);
        chk("rst_abort_valid", {28'h0, vld}, 32'h0);
        for (int unsigned i = 0; i < 4; i++) chk("rst_abort_result", res[i], 32'h0);
        repeat (3) begin
            tick();
            chk("rst_no_valid", {28'h0, vld}, 32'h0);
        end

        // Random sweep including reserved ops
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            sh = $urandom_range(0, 31);
            run($sformatf("rnd%0d_op%0d_sh%0d", n, op, sh), op, x, sh, ref_model(op, x, sh));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
